// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// No logic of its own; imported by the arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Requester index `step` places after `idx`, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n, input int step);
    return (idx + step) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant, with wrap.
// Zero latency; no handshake of its own.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_vld,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  pick_id,
  output logic             pick_valid
);

  int idx;

  always_comb begin
    pick_id    = '0;
    pick_valid = 1'b0;
    idx        = 0;
    // Offsets 1..N_REQ put last_grant itself at the lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = wrap_inc(int'(last_grant), N_REQ, k);
      if (!pick_valid && req_vld[ID_W'(idx)]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready requesters.
// One idle bubble per grant; beats pass combinationally and stall while fifo_full is high.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     w_clk,
  input  logic                     aresetn,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     fifo_full,
  output logic [WIDTH-1:0]         fifo_w_data,
  output logic                     fifo_w_enable,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  pick_id;
  logic             pick_valid;
  logic             granted;
  logic             beat;
  logic [WIDTH-1:0] slice [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign slice[i] = req_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_vld    (req_valid),
    .last_grant (last_q),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  // Gating with aresetn keeps every output low during reset, even mid-burst.
  assign granted = aresetn && (state_q == ARB_GRANT);
  assign beat    = granted && req_valid[grant_q] && !fifo_full;

  always_ff @(posedge w_clk) begin
    if (!aresetn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_GRANT;
          grant_d = pick_id;
          last_d  = pick_id;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        // Burst end wins over a dropped valid; full alone freezes everything.
        if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = ARB_IDLE;
        end else if (!req_valid[grant_q]) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (granted) req_ready[grant_q] = !fifo_full;
    fifo_w_enable = beat;
    fifo_w_data   = beat ? slice[grant_q] : '0;
    grant_id      = aresetn ? grant_q : '0;
    busy          = granted;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-port arbiter placed in front of the write side of `ASYNC_FIFO`. It shares the single FIFO write port among `N_REQ` requesters in the write clock domain. Each requester uses a valid/ready handshake. A grant lasts for a bounded burst, and the arbiter stalls on `full`. Its outputs connect directly to the FIFO's `w_data`, `w_enable` and `full` pins.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 8: data width; matches the FIFO `WIDTH`.
- `MAX_BURST`, default 4: maximum beats per grant, ≥1.
- `w_clk`  in  1: write-domain clock; all logic on its rising edge.
- `aresetn`  in  1: reset, synchronous to `w_clk`, active-low.
- `req_valid`  in  N_REQ: per-requester data valid.
- `req_data`  in  N_REQ*WIDTH: requester i data in bits [i*WIDTH +: WIDTH].
- `req_ready`  out  N_REQ: per-requester accept; a beat transfers on valid & ready.
- `fifo_full`  in  1: FIFO `full` flag.
- `fifo_w_data`  out  WIDTH: to FIFO `w_data`.
- `fifo_w_enable`  out  1: to FIFO `w_enable`.
- `grant_id`  out  $clog2(N_REQ): currently or last granted requester.
- `busy`  out  1: high while in GRANT.

## Operation
- **States:** ARB_IDLE and ARB_GRANT.
- **Registers:** `state`, `grant_id`, `last_grant`, `burst_cnt` ($clog2(MAX_BURST+1) bits).
- **ARB_IDLE:**
  - If any `req_valid` is high, pick the first valid requester searching from `last_grant+1` mod `N_REQ` upward with wrap.
  - Latch it into `grant_id` and `last_grant`, clear `burst_cnt`, and go to ARB_GRANT.
  - Otherwise stay in ARB_IDLE.
- **ARB_GRANT, with g = grant_id:**
  - `req_ready[g] = !fifo_full`. All other `req_ready` bits are 0.
  - Beat = `req_valid[g] & !fifo_full`. A beat increments `burst_cnt`.
  - `fifo_full` high: no beat, counter frozen, grant held for any number of cycles.
- **Exit to ARB_IDLE**, evaluated in priority order:
  - (a) A beat occurs with `burst_cnt == MAX_BURST-1`.
  - (b) `req_valid[g]` is low in a cycle, even if `fifo_full` is also high.
  - Otherwise stay in ARB_GRANT.
- **Requester rule:** once `req_valid` is asserted, hold it and its data stable until accepted. Deasserting `req_valid` while granted forfeits the grant.
- **Datapath (combinational):**
  - `fifo_w_enable = (state==ARB_GRANT) & req_valid[g] & !fifo_full & aresetn`.
  - `fifo_w_data` = slice g of `req_data` when `fifo_w_enable` is high, else 0.
- **Overflow:** the arbiter never asserts `fifo_w_enable` while `fifo_full` is high.
- **Reset:**
  - `state` = ARB_IDLE, `grant_id` = 0, `last_grant` = N_REQ-1 (so requester 0 wins first), `burst_cnt` = 0.
  - All outputs are 0 while `aresetn` is low, including the combinational ones.
  - Reset mid-burst drops the grant. No partial beat is written.

## Timing
- **Arbitration latency:** 1 cycle. The first cycle `req_valid` is high is the ARB_IDLE decision edge, and `req_ready` rises in the next cycle.
- **Beat latency:** 0. Data reaches the FIFO pins in the same cycle as the handshake.
- **Gap between grants:** one ARB_IDLE bubble cycle after each exit. Sustained throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- **`fifo_full`:** sampled combinationally in the current cycle. The FIFO updates `full` on the writing edge, so no beat is lost or duplicated.
- **`busy`:** equals `state == ARB_GRANT`.

## Structure
- **Package `fifo_arb_pkg`:** `arb_state_t` enum {ARB_IDLE, ARB_GRANT}.
- **Sub-module `rr_pick`:**
  - Parameterised on `N_REQ`; purely combinational.
  - Inputs: request vector and `last_grant`.
  - Outputs: `pick_id` and `pick_valid`.
- **Top level:** the state machine, counters and data mux.

## Test plan
All scenarios use N_REQ=4, WIDTH=8, MAX_BURST=4, with the FIFO at DEPTH=8 and `r_clk` faster than `w_clk`.
- **Reset:** hold `aresetn` low for 3 cycles with all `req_valid` high -> `req_ready`, `fifo_w_enable`, `fifo_w_data`, `busy` and `grant_id` are all 0. The first grant after release goes to requester 0.
- **Long single request:** requester 2 only, data 0x10..0x15 -> 1 idle cycle, then 0x10..0x13 in 4 consecutive cycles, 1 idle cycle, regrant to 2, then 0x14 and 0x15.
- **All requesters busy:** all four valid continuously -> `grant_id` sequence 0,1,2,3,0, with 4 beats each and 5 cycles per grant.
- **Full stall:** `fifo_full` forced high for 5 cycles at the third beat of a burst -> `fifo_w_enable` and `req_ready` are 0 and the grant is held. The third beat is written on the first cycle after `full` falls, and the burst totals exactly 4 beats.
- **Early release:** requester 1 drops valid after 2 beats while requester 3 is valid -> 1 idle cycle, then grant 3. Requester 1 gets no further `req_ready` until its next turn.
- **Reset mid-burst:** `aresetn` low during beat 2 of a requester-2 burst -> `fifo_w_enable` is 0 in that same cycle. After release, the next grant goes to requester 0.
